// File: rtl/ram_dp_be_pkg.sv
// Shared SoC memory-map and control constants used by the dual-port data RAM.
package ram_dp_be_pkg;

  localparam logic [31:0] RAM_BASE     = 32'h0000_0000;
  localparam int          RAM_DEPTH    = 4096;
  localparam logic        WRITE_ENABLE = 1'b1;
  localparam logic        RST_ENABLE   = 1'b1;

endpackage

// File: rtl/ram_port_rsp.sv
// One RAM port front end: address check, request ready and the registered
// response (valid/err/rdata gate) that holds under backpressure.
module ram_port_rsp
  import ram_dp_be_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 32,
  parameter int                DEPTH     = RAM_DEPTH,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(RAM_BASE),
  localparam int               IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  input  logic              req_we_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic              rsp_ready_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic              req_ready_o,
  output logic              ok_o,
  output logic [IDX_W-1:0]  idx_o,
  output logic              rsp_valid_o,
  output logic              rsp_err_o,
  output logic [DATA_W-1:0] rsp_rdata_o
);

  localparam int                BYTES      = DATA_W / 8;
  localparam int                OFF_W      = $clog2(BYTES);
  localparam logic [ADDR_W:0]   SPAN       = (ADDR_W+1)'(DEPTH * BYTES);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(BYTES - 1);

  logic [ADDR_W-1:0] off;
  logic              err;
  logic              acc;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rdata_sel_q, rdata_sel_d;

  assign off   = req_addr_i - BASE_ADDR;
  assign err   = (req_addr_i < BASE_ADDR) || ({1'b0, off} >= SPAN) ||
                 ((off & ALIGN_MASK) != '0);
  assign idx_o = IDX_W'(off >> OFF_W);

  assign req_ready_o = (rst != RST_ENABLE) && (!rsp_valid_q || rsp_ready_i);
  assign acc         = req_valid_i && req_ready_o;
  assign ok_o        = acc && !err;

  // rdata_sel gates the array output so writes, errors and idle read as zero
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rdata_sel_d = rdata_sel_q;
    if (acc) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = err;
      rdata_sel_d = !err && (req_we_i != WRITE_ENABLE);
    end else if (rsp_ready_i) begin
      rsp_valid_d = 1'b0;
      rsp_err_d   = 1'b0;
      rdata_sel_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rdata_sel_q <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rdata_sel_q <= rdata_sel_d;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_err_o   = rsp_err_q;
  assign rsp_rdata_o = rdata_sel_q ? rdata_i : '0;

  a_cfg: assert property (@(posedge clk) (DATA_W % 8 == 0) && (DEPTH >= 2));
  a_hold: assert property (@(posedge clk) disable iff (rst)
    rsp_valid_o && !rsp_ready_i |=> rsp_valid_o && $stable(rsp_err_o) && $stable(rsp_rdata_o));

endmodule

// File: rtl/ram_dp_be.sv
// Dual-port RAM: port A read/write with byte enables, port B read-only.
// Holds the array, byte merge and same-word A-write/B-read collision handling.
module ram_dp_be
  import ram_dp_be_pkg::*;
#(
  parameter int                DATA_W         = 32,
  parameter int                ADDR_W         = 32,
  parameter int                DEPTH          = RAM_DEPTH,
  parameter logic [ADDR_W-1:0] BASE_ADDR      = ADDR_W'(RAM_BASE),
  parameter int                COLLIDE_RD_NEW = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                a_req_valid_i,
  output logic                a_req_ready_o,
  input  logic                a_req_we_i,
  input  logic [ADDR_W-1:0]   a_req_addr_i,
  input  logic [DATA_W-1:0]   a_req_wdata_i,
  input  logic [DATA_W/8-1:0] a_req_be_i,
  output logic                a_rsp_valid_o,
  input  logic                a_rsp_ready_i,
  output logic [DATA_W-1:0]   a_rsp_rdata_o,
  output logic                a_rsp_err_o,
  input  logic                b_req_valid_i,
  output logic                b_req_ready_o,
  input  logic [ADDR_W-1:0]   b_req_addr_i,
  output logic                b_rsp_valid_o,
  input  logic                b_rsp_ready_i,
  output logic [DATA_W-1:0]   b_rsp_rdata_o,
  output logic                b_rsp_err_o
);

  localparam int BYTES = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              a_ok, b_ok, a_wr, collide;
  logic [IDX_W-1:0]  a_idx, b_idx;
  logic [DATA_W-1:0] a_old, b_old, a_merged;
  logic [DATA_W-1:0] a_rd_q, a_rd_d, b_rd_q, b_rd_d;

  function automatic logic [DATA_W-1:0] be_merge(input logic [DATA_W-1:0] old_w,
                                                 input logic [DATA_W-1:0] new_w,
                                                 input logic [BYTES-1:0]  be);
    be_merge = old_w;
    for (int i = 0; i < BYTES; i++)
      if (be[i]) be_merge[8*i +: 8] = new_w[8*i +: 8];
  endfunction

  ram_port_rsp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE_ADDR(BASE_ADDR)) u_port_a (
    .clk(clk), .rst(rst),
    .req_valid_i(a_req_valid_i), .req_we_i(a_req_we_i), .req_addr_i(a_req_addr_i),
    .rsp_ready_i(a_rsp_ready_i), .rdata_i(a_rd_q),
    .req_ready_o(a_req_ready_o), .ok_o(a_ok), .idx_o(a_idx),
    .rsp_valid_o(a_rsp_valid_o), .rsp_err_o(a_rsp_err_o), .rsp_rdata_o(a_rsp_rdata_o)
  );

  ram_port_rsp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE_ADDR(BASE_ADDR)) u_port_b (
    .clk(clk), .rst(rst),
    .req_valid_i(b_req_valid_i), .req_we_i(1'b0), .req_addr_i(b_req_addr_i),
    .rsp_ready_i(b_rsp_ready_i), .rdata_i(b_rd_q),
    .req_ready_o(b_req_ready_o), .ok_o(b_ok), .idx_o(b_idx),
    .rsp_valid_o(b_rsp_valid_o), .rsp_err_o(b_rsp_err_o), .rsp_rdata_o(b_rsp_rdata_o)
  );

  assign a_old    = mem[a_idx];
  assign b_old    = mem[b_idx];
  assign a_wr     = a_ok && (a_req_we_i == WRITE_ENABLE);
  assign a_merged = be_merge(a_old, a_req_wdata_i, a_req_be_i);
  assign collide  = a_wr && b_ok && (a_idx == b_idx);

  // Read registers only load on accept so a stalled response keeps its data
  always_comb begin
    a_rd_d = a_rd_q;
    b_rd_d = b_rd_q;
    if (a_ok) a_rd_d = a_old;
    if (b_ok) b_rd_d = (COLLIDE_RD_NEW != 0 && collide) ? a_merged : b_old;
  end

  always_ff @(posedge clk) begin
    a_rd_q <= a_rd_d;
    b_rd_q <= b_rd_d;
    for (int i = 0; i < BYTES; i++)
      if (a_wr && a_req_be_i[i]) mem[a_idx][8*i +: 8] <= a_req_wdata_i[8*i +: 8];
  end

endmodule

// File: tb/tb_ram_dp_be.sv
// Randomized self-checking bench for ram_dp_be against a transaction-level memory model.
module tb_ram_dp_be;

  localparam int          DW    = 32;
  localparam int          AW    = 32;
  localparam int          DEPTH = 64;
  localparam int          NB    = DW / 8;
  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          COLL  = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          a_req_valid_i, a_req_ready_o, a_req_we_i;
  logic [AW-1:0] a_req_addr_i;
  logic [DW-1:0] a_req_wdata_i;
  logic [NB-1:0] a_req_be_i;
  logic          a_rsp_valid_o, a_rsp_ready_i, a_rsp_err_o;
  logic [DW-1:0] a_rsp_rdata_o;
  logic          b_req_valid_i, b_req_ready_o;
  logic [AW-1:0] b_req_addr_i;
  logic          b_rsp_valid_o, b_rsp_ready_i, b_rsp_err_o;
  logic [DW-1:0] b_rsp_rdata_o;

  always #5 clk = ~clk;

  ram_dp_be #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .BASE_ADDR(BASE), .COLLIDE_RD_NEW(COLL)) dut (
    .clk(clk), .rst(rst),
    .a_req_valid_i(a_req_valid_i), .a_req_ready_o(a_req_ready_o), .a_req_we_i(a_req_we_i),
    .a_req_addr_i(a_req_addr_i), .a_req_wdata_i(a_req_wdata_i), .a_req_be_i(a_req_be_i),
    .a_rsp_valid_o(a_rsp_valid_o), .a_rsp_ready_i(a_rsp_ready_i),
    .a_rsp_rdata_o(a_rsp_rdata_o), .a_rsp_err_o(a_rsp_err_o),
    .b_req_valid_i(b_req_valid_i), .b_req_ready_o(b_req_ready_o), .b_req_addr_i(b_req_addr_i),
    .b_rsp_valid_o(b_rsp_valid_o), .b_rsp_ready_i(b_rsp_ready_i),
    .b_rsp_rdata_o(b_rsp_rdata_o), .b_rsp_err_o(b_rsp_err_o)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference memory; a word is "known" once fully written by the bench
  logic [31:0] ref_mem   [DEPTH];
  bit          ref_known [DEPTH];
  bit          ea_v, ea_e, ea_k, eb_v, eb_e, eb_k;
  logic [31:0] ea_d, eb_d;
  bit          was_rst = 1'b1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit addr_bad(input logic [31:0] a);
    longint off;
    off = longint'(a) - longint'(BASE);
    return (off < 0) || (off >= longint'(DEPTH * NB)) || (off % NB != 0);
  endfunction

  function automatic int idx_of(input logic [31:0] a);
    return int'((longint'(a) - longint'(BASE)) / NB);
  endfunction

  function automatic logic [31:0] rnd_addr();
    int          k;
    logic [31:0] w;
    k = int'($urandom_range(99));
    w = BASE + 32'(4 * $urandom_range(DEPTH - 1));
    if (k < 80) return w;
    if (k < 90) return w + 32'($urandom_range(3, 1));
    if (k < 95) return BASE + 32'(DEPTH * NB) + 32'(4 * $urandom_range(7));
    return BASE - 32'(4 * $urandom_range(8, 1));
  endfunction

  task automatic set_a(input bit v, input bit we, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [3:0] be);
    a_req_valid_i = v; a_req_we_i = we; a_req_addr_i = addr;
    a_req_wdata_i = wd; a_req_be_i = be;
  endtask

  task automatic set_b(input bit v, input logic [31:0] addr);
    b_req_valid_i = v; b_req_addr_i = addr;
  endtask

  // Called just after a negedge with inputs driven: check outputs, advance the model one edge
  task automatic step();
    bit ra, rb, acc_a, acc_b;
    int ia, ib;
    #1;
    ra = !rst && (!ea_v || a_rsp_ready_i);
    rb = !rst && (!eb_v || b_rsp_ready_i);
    chk("a_req_ready", 64'(a_req_ready_o), 64'(ra));
    chk("b_req_ready", 64'(b_req_ready_o), 64'(rb));
    chk("a_rsp_valid", 64'(a_rsp_valid_o), 64'(ea_v));
    chk("b_rsp_valid", 64'(b_rsp_valid_o), 64'(eb_v));
    if (ea_v) chk("a_rsp_err", 64'(a_rsp_err_o), 64'(ea_e));
    if (eb_v) chk("b_rsp_err", 64'(b_rsp_err_o), 64'(eb_e));
    if (ea_v && ea_k) chk("a_rsp_rdata", 64'(a_rsp_rdata_o), 64'(ea_d));
    if (eb_v && eb_k) chk("b_rsp_rdata", 64'(b_rsp_rdata_o), 64'(eb_d));
    if (was_rst) begin
      chk("rst_a_rdata", 64'(a_rsp_rdata_o), 64'd0);
      chk("rst_a_err",   64'(a_rsp_err_o),   64'd0);
      chk("rst_b_rdata", 64'(b_rsp_rdata_o), 64'd0);
      chk("rst_b_err",   64'(b_rsp_err_o),   64'd0);
    end
    was_rst = rst;
    if (rst) begin
      ea_v = 1'b0;
      eb_v = 1'b0;
    end else begin
      acc_a = a_req_valid_i && ra;
      acc_b = b_req_valid_i && rb;
      if (acc_b) begin
        eb_v = 1'b1;
        eb_e = addr_bad(b_req_addr_i);
        ib   = eb_e ? 0 : idx_of(b_req_addr_i);
        eb_d = eb_e ? 32'h0 : ref_mem[ib];
        eb_k = eb_e || ref_known[ib];
      end else if (b_rsp_ready_i) eb_v = 1'b0;
      if (acc_a) begin
        ea_v = 1'b1;
        ea_e = addr_bad(a_req_addr_i);
        ia   = ea_e ? 0 : idx_of(a_req_addr_i);
        ea_d = (ea_e || a_req_we_i) ? 32'h0 : ref_mem[ia];
        ea_k = ea_e || a_req_we_i || ref_known[ia];
        if (!ea_e && a_req_we_i) begin
          for (int i = 0; i < NB; i++)
            if (a_req_be_i[i]) ref_mem[ia][8*i +: 8] = a_req_wdata_i[8*i +: 8];
          if (a_req_be_i == '1) ref_known[ia] = 1'b1;
          if (COLL != 0 && acc_b && !eb_e && ib == ia) begin
            eb_d = ref_mem[ia];
            eb_k = ref_known[ia];
          end
        end
      end else if (a_rsp_ready_i) ea_v = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    a_rsp_ready_i = 1'b1;
    b_rsp_ready_i = 1'b1;
    set_a(1'b1, 1'b1, BASE, 32'h0BAD_0BAD, 4'hF);
    set_b(1'b1, BASE);
    @(negedge clk);
    repeat (3) step();

    // First access after reset release: read of word 0
    rst = 1'b0;
    set_a(1'b1, 1'b0, BASE, 32'h0, 4'h0);
    set_b(1'b0, BASE);
    step();
    set_a(1'b0, 1'b0, BASE, 32'h0, 4'h0);
    step();

    for (int i = 0; i < DEPTH; i++) begin
      set_a(1'b1, 1'b1, BASE + 32'(4 * i), $urandom, 4'hF);
      step();
    end

    set_a(1'b1, 1'b1, BASE + 32'h10, 32'h1122_3344, 4'hF); step();
    set_a(1'b1, 1'b1, BASE + 32'h10, 32'hDEAD_BEEF, 4'b0101); step();
    set_a(1'b1, 1'b0, BASE + 32'h10, 32'h0, 4'h0); step();
    chk("be_merge_rdata", 64'(a_rsp_rdata_o), 64'h11AD_33EF);

    set_a(1'b1, 1'b1, BASE + 32'h3, 32'hFFFF_FFFF, 4'hF); step();
    chk("misalign_err", 64'(a_rsp_err_o), 64'd1);
    set_a(1'b1, 1'b1, BASE + 32'(DEPTH * NB), 32'hFFFF_FFFF, 4'hF); step();
    chk("range_err", 64'(a_rsp_err_o), 64'd1);
    set_a(1'b1, 1'b0, BASE - 32'h4, 32'h0, 4'h0); step();
    chk("below_base_err", 64'(a_rsp_err_o), 64'd1);
    set_a(1'b1, 1'b0, BASE, 32'h0, 4'h0); step();
    set_a(1'b1, 1'b0, BASE + 32'h10, 32'h0, 4'h0); step();
    chk("after_err_rdata", 64'(a_rsp_rdata_o), 64'h11AD_33EF);

    // B stream, then B backpressure while A keeps going
    set_a(1'b0, 1'b0, BASE, 32'h0, 4'h0);
    for (int i = 0; i < 8; i++) begin
      set_b(1'b1, BASE + 32'(4 * i));
      step();
    end
    b_rsp_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_b(1'b1, BASE + 32'h40);
      set_a(1'b1, 1'b0, BASE + 32'(4 * i), 32'h0, 4'h0);
      step();
    end
    b_rsp_ready_i = 1'b1;
    set_b(1'b0, BASE);
    step();

    set_a(1'b1, 1'b1, BASE + 32'h20, 32'h0, 4'hF); step();
    set_a(1'b1, 1'b1, BASE + 32'h20, 32'hCAFE_F00D, 4'hF);
    set_b(1'b1, BASE + 32'h20);
    step();
    chk("collide_b_rdata", 64'(b_rsp_rdata_o), 64'hCAFE_F00D);
    set_a(1'b0, 1'b0, BASE, 32'h0, 4'h0);
    step();
    chk("after_collide_b", 64'(b_rsp_rdata_o), 64'hCAFE_F00D);
    set_b(1'b0, BASE);
    step();

    for (int c = 0; c < 500; c++) begin
      rst = ($urandom_range(99) == 0);
      a_rsp_ready_i = ($urandom_range(3) != 0);
      b_rsp_ready_i = ($urandom_range(3) != 0);
      set_a($urandom_range(9) < 7, 1'($urandom_range(1)), rnd_addr(), $urandom, 4'($urandom));
      set_b($urandom_range(9) < 7, rnd_addr());
      step();
    end
    rst = 1'b0;
    a_rsp_ready_i = 1'b1;
    b_rsp_ready_i = 1'b1;
    set_b(1'b0, BASE);
    set_a(1'b1, 1'b1, BASE + 32'h40, 32'h5555_AAAA, 4'hF); step();

    // Reset with a stalled A response, write presented during reset
    a_rsp_ready_i = 1'b0;
    set_a(1'b1, 1'b0, BASE + 32'h40, 32'h0, 4'h0); step();
    chk("stall_valid", 64'(a_rsp_valid_o), 64'd1);
    rst = 1'b1;
    set_a(1'b1, 1'b1, BASE + 32'h40, 32'h1234_5678, 4'hF); step();
    chk("rst_drop_valid", 64'(a_rsp_valid_o), 64'd0);
    rst = 1'b0;
    a_rsp_ready_i = 1'b1;
    set_a(1'b1, 1'b0, BASE + 32'h40, 32'h0, 4'h0); step();
    chk("rst_no_write", 64'(a_rsp_rdata_o), 64'h5555_AAAA);
    set_a(1'b0, 1'b0, BASE, 32'h0, 4'h0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_dp_be.md
Name: ram_dp_be

Overview:
- Parametrised dual-port on-chip RAM; successor to the single-port SoC data RAM.
- Port A: read/write with byte enables (data side). Port B: read-only (instruction fetch side).
- Each port has a valid/ready request channel and a registered response channel with backpressure.
- Responses carry an error flag for out-of-range or misaligned accesses. Array maps to inferred block RAM (synchronous read).

Parameters:
- DATA_W, 32, data width in bits (multiple of 8)
- ADDR_W, 32, byte address width
- DEPTH, 4096, number of DATA_W words
- BASE_ADDR, 32'h0000_0000, byte address of word 0
- COLLIDE_RD_NEW, 0, same-cycle A-write/B-read of one word: 0 = B gets old data, 1 = B gets merged new data

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- a_req_valid_i  in  1  port A request valid
- a_req_ready_o  out  1  port A request ready
- a_req_we_i  in  1  1 = write, 0 = read
- a_req_addr_i  in  ADDR_W  byte address
- a_req_wdata_i  in  DATA_W  write data
- a_req_be_i  in  DATA_W/8  byte enables; bit i covers byte i
- a_rsp_valid_o  out  1  port A response valid
- a_rsp_ready_i  in  1  port A response accepted
- a_rsp_rdata_o  out  DATA_W  read data; 0 for writes and errors
- a_rsp_err_o  out  1  access error
- b_req_valid_i  in  1  port B request valid
- b_req_ready_o  out  1  port B request ready
- b_req_addr_i  in  ADDR_W  byte address
- b_rsp_valid_o  out  1  port B response valid
- b_rsp_ready_i  in  1  port B response accepted
- b_rsp_rdata_o  out  DATA_W  read data; 0 on error
- b_rsp_err_o  out  1  access error

Behaviour:
- Reset values: all rsp_valid, rsp_rdata and rsp_err outputs are 0. req_ready_o is forced to 0 while rst=1. Array contents are not reset.
- Ready: x_req_ready_o = !rst && (!x_rsp_valid_o || x_rsp_ready_i). This gives throughput of 1 request/cycle per port under no backpressure.
- Accept: a request is accepted on a clk edge where valid && ready.
- Latency: the response is valid in the cycle after acceptance (1-cycle latency).
- Response hold: the response holds stable until rsp_valid && rsp_ready. If no new request is accepted on that edge, rsp_valid drops to 0.
- Address check:
  - off = addr - BASE_ADDR.
  - Error if addr < BASE_ADDR, or off >= DEPTH*DATA_W/8, or off[log2(DATA_W/8)-1:0] != 0.
  - Word index idx = off >> log2(DATA_W/8).
- Error response: err=1, rdata=0. No array write occurs, even if we=1.
- Port A write:
  - Only bytes with be[i]=1 are updated; be=0 is a legal no-op write.
  - A response (err per address check, rdata=0) is still returned.
- Port A read: rdata = word at idx before any same-edge write (read-first).
- Port B read: rdata = word at idx.
- Collision (A write and B read accepted on the same edge, same idx, no error):
  - COLLIDE_RD_NEW=0: B returns old word.
  - COLLIDE_RD_NEW=1: B returns old word with the enabled bytes replaced by a_req_wdata_i.
- Ports are fully independent; a stall on one port never affects the other.
- Reset mid-operation: pending responses are discarded (valid->0). A request presented during rst is not accepted and no write occurs.
- Sim-only assertions: DATA_W % 8 == 0; DEPTH >= 2; rsp payload stable while valid && !ready.

Decomposition:
- Shared defines file (the existing SoC defines header) holds: RAM base/depth constants for the SoC memory map, WriteEnable/RstEnable and ZeroWord.
- Sub-module ram_port_rsp: address check, ready logic and response register. Instantiated once per port; B's instance has we tied 0. The top holds the array, byte-merge and collision logic.

Test Plan:
- Reset then A read idx 0 (addr 0x0) -> ready=0 during rst; after release, rsp_valid one cycle after accept, err=0, rsp_valid=0 on the reset-release cycle.
- A write addr 0x10 data 0xDEADBEEF be=4'b0101 over prior 0x11223344, then A read 0x10 -> rdata 0x11AD33EF, err=0.
- A read addr 0x3 (misaligned) and addr BASE+DEPTH*4 (out of range) -> err=1, rdata=0; a following read shows the array unchanged after the erroring write attempt.
- B stream of 8 back-to-back reads with b_rsp_ready_i=1 -> one response per cycle. Then hold b_rsp_ready_i=0 for 3 cycles -> b_req_ready_o=0, payload stable, A port keeps streaming.
- Same-edge A write 0xCAFEF00D be=4'hF and B read, same addr holding 0x0 -> B rdata 0x0 (COLLIDE_RD_NEW=0) / 0xCAFEF00D (=1); a later B read returns 0xCAFEF00D.
- Assert rst while A response pending and a_rsp_ready_i=0 -> a_rsp_valid_o=0 next cycle; a write presented during rst leaves memory unmodified.
